// File: rtl/iq_frame_packer.sv
// Pairs I/Q sample strobes into 64-bit FIFO words and inserts a framing
// header ahead of every FRAME_SAMPLES sample words.
module iq_frame_packer #(
  parameter int unsigned FRAME_SAMPLES = 512,
  parameter int unsigned PAIR_TIMEOUT  = 256,
  parameter logic [15:0] SYNC_WORD     = 16'hA55A
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        enable,
  input  logic        stats_clr,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  input  logic [31:0] q_data,
  input  logic        q_valid,
  input  logic        fifo_full,
  output logic [63:0] fifo_wdata,
  output logic        fifo_we,
  output logic [15:0] frame_seq,
  output logic [15:0] overflow_cnt,
  output logic [7:0]  err_cnt,
  output logic        pair_err
);

  localparam int IDX_W = $clog2(FRAME_SAMPLES);
  localparam int TMO_W = $clog2(PAIR_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PAIR, EMIT_HDR, EMIT_SMP} state_t;

  state_t             state, state_nxt;
  logic [31:0]        i_hold, q_hold;
  logic               i_have, q_have;
  logic [63:0]        smp_reg;
  logic [IDX_W-1:0]   word_idx, word_idx_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               flush, pair_ok, one_have, tmo_hit, i_ovw, q_ovw, consume;
  logic               seq_inc, ovf_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign flush    = (state == IDLE) || !enable;
  assign pair_ok  = i_have && q_have;
  assign one_have = i_have ^ q_have;
  // Fires in the PAIR_TIMEOUT-th cycle counted from the lone strobe itself.
  assign tmo_hit  = one_have && (tmo_cnt == TMO_W'(PAIR_TIMEOUT - 1));
  assign i_ovw    = i_valid && i_have && !q_have;
  assign q_ovw    = q_valid && q_have && !i_have;
  assign pair_err = !flush && (i_ovw || q_ovw || tmo_hit);
  assign consume  = (state == WAIT_PAIR) && pair_ok && enable;

  // Pairing holds: a new strobe reloads its flag even in a consume/timeout cycle
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      i_hold  <= '0;
      q_hold  <= '0;
      i_have  <= 1'b0;
      q_have  <= 1'b0;
      tmo_cnt <= '0;
    end else if (flush) begin
      i_have  <= 1'b0;
      q_have  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (i_valid) i_hold <= i_data;
      if (q_valid) q_hold <= q_data;
      i_have  <= i_valid || (i_have && !consume && !tmo_hit);
      q_have  <= q_valid || (q_have && !consume && !tmo_hit);
      tmo_cnt <= (one_have && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    seq_inc      = 1'b0;
    ovf_inc      = 1'b0;
    fifo_we      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt    = WAIT_PAIR;
          word_idx_nxt = '0;
        end
      end
      WAIT_PAIR: begin
        if (pair_ok) state_nxt = (word_idx == '0) ? EMIT_HDR : EMIT_SMP;
      end
      EMIT_HDR: begin
        if (!fifo_full) begin
          fifo_we   = 1'b1;
          seq_inc   = 1'b1;
          state_nxt = EMIT_SMP;
        end else begin
          ovf_inc   = 1'b1;
          state_nxt = WAIT_PAIR;
        end
      end
      EMIT_SMP: begin
        state_nxt = WAIT_PAIR;
        if (!fifo_full) begin
          fifo_we      = 1'b1;
          word_idx_nxt = (word_idx == IDX_W'(FRAME_SAMPLES - 1)) ? '0 : word_idx + 1'b1;
        end else begin
          ovf_inc      = 1'b1;
          word_idx_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A write already in flight this cycle still completes; only the next state is forced.
    if (!enable) begin
      state_nxt    = IDLE;
      word_idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state        <= IDLE;
      word_idx     <= '0;
      smp_reg      <= '0;
      frame_seq    <= '0;
      overflow_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
      if (consume) smp_reg <= {i_hold, q_hold};
      if (seq_inc) frame_seq <= frame_seq + 16'd1;
      if (stats_clr) begin
        overflow_cnt <= '0;
        err_cnt      <= '0;
      end else begin
        if (ovf_inc)  overflow_cnt <= sat_inc16(overflow_cnt);
        if (pair_err) err_cnt      <= sat_inc8(err_cnt);
      end
    end
  end

  assign fifo_wdata = (state == EMIT_HDR)
                    ? {SYNC_WORD, frame_seq, overflow_cnt, 16'(FRAME_SAMPLES)}
                    : smp_reg;

endmodule

// File: doc/iq_frame_packer.md
Name:
iq_frame_packer

Overview:
- Sits between the two adc_if instances (I and Q channels) and adc_fifo, on the system clock domain.
- Pairs the I and Q sample strobes into 64-bit FIFO words.
- Inserts a framing header word every FRAME_SAMPLES samples.
- Owns the FIFO write strobe and accounts for samples dropped on fifo_full, so the host side can resynchronise on headers.

Parameters:
- FRAME_SAMPLES, 512: sample words per frame following each header; must be ≥2.
- PAIR_TIMEOUT, 256: clk cycles a lone I or Q sample waits for its partner before being discarded.
- SYNC_WORD, 16'hA55A: header marker in bits [63:48].

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- enable  in  1  packing enable; low = idle and flush
- stats_clr  in  1  single-cycle pulse; clears overflow_cnt and err_cnt
- i_data  in  32  I-channel sample
- i_valid  in  1  single-cycle strobe; i_data valid
- q_data  in  32  Q-channel sample
- q_valid  in  1  single-cycle strobe; q_data valid
- fifo_full  in  1  FIFO full flag (clk domain)
- fifo_wdata  out  64  FIFO write data
- fifo_we  out  1  FIFO write enable
- frame_seq  out  16  sequence number of the next header
- overflow_cnt  out  16  saturating count of words dropped on fifo_full
- err_cnt  out  8  saturating count of pairing errors
- pair_err  out  1  single-cycle pulse on any pairing error

Behaviour:
- Reset (arstn low, async): all outputs 0, FSM=IDLE, holds empty, word_idx=0, timeout counter 0.
- Pairing (independent of the FSM):
  - i_valid loads i_hold and sets i_have; q_valid loads q_hold and sets q_have. Both in the same cycle is legal.
  - Same-channel strobe while its have flag is set and the partner is absent: hold overwritten, pair_err pulses, err_cnt += 1.
  - Pair complete when i_have & q_have.
- Timeout: counter runs while exactly one have flag is set and resets otherwise. When it reaches PAIR_TIMEOUT: clear both flags, pair_err pulse, err_cnt += 1.
- FSM states: IDLE, WAIT_PAIR, EMIT_HDR, EMIT_SMP.
  - IDLE: holds forced empty. enable=1 → WAIT_PAIR with word_idx=0.
  - WAIT_PAIR: on pair complete, latch {i_hold, q_hold} into smp_reg and clear both have flags. word_idx==0 → EMIT_HDR, else → EMIT_SMP.
  - EMIT_HDR:
    - !fifo_full: fifo_we=1, fifo_wdata={SYNC_WORD, frame_seq, overflow_cnt, FRAME_SAMPLES[15:0]}; frame_seq += 1 (wraps 16'hFFFF→0); → EMIT_SMP.
    - fifo_full: no write, overflow_cnt += 1, sample discarded, word_idx stays 0, → WAIT_PAIR.
  - EMIT_SMP:
    - !fifo_full: fifo_we=1, fifo_wdata=smp_reg (I in [63:32], Q in [31:0]); word_idx += 1, wrapping to 0 after FRAME_SAMPLES-1; → WAIT_PAIR.
    - fifo_full: no write, overflow_cnt += 1, word_idx=0 (next accepted sample opens a new frame), → WAIT_PAIR.
- fifo_we is combinational: (state is EMIT_HDR or EMIT_SMP) & !fifo_full. fifo_wdata is valid whenever fifo_we=1; otherwise it is don't-care but driven from registers.
- Latency: pair completes in cycle N. Header frame: header at N+1, sample at N+2. Non-header frame: sample at N+1.
- Pairs arriving during EMIT states wait in the holds; no sample is lost if pairs are ≥3 cycles apart.
- enable falling: current-cycle write, if any, completes. Next state is IDLE, holds flushed, word_idx=0. frame_seq, overflow_cnt and err_cnt are retained.
- stats_clr: clears overflow_cnt and err_cnt and takes priority over a same-cycle increment.
- Saturation: overflow_cnt holds at 16'hFFFF; err_cnt holds at 8'hFF.
- Header field uses the overflow_cnt value before any same-cycle increment.

Test Plan:
- FRAME_SAMPLES=4; enable; 5 aligned pairs I=32'h100+k, Q=32'h200+k:
  - Required: writes are header {A55A, 0000, 0000, 0004}, 4 samples {00000100, 00000200}…, header {A55A, 0001, 0000, 0004}, sample k=4.
  - Required: frame_seq=2 at end.
- I strobe at cycle 0, Q strobe at cycle 7 → exactly one sample word written; pair_err never asserted.
- I strobe only, PAIR_TIMEOUT=16 → pair_err pulse at cycle 16, err_cnt=1, no FIFO write. Two I strobes before a Q → err_cnt=1 and the written word carries the second I.
- fifo_full held high across the sample write of frame word 2 → no write, overflow_cnt=1. Next pair emits header {A55A, 0001, 0001, …} then the sample.
- fifo_full during a header → overflow_cnt=1, frame_seq unchanged. Next pair writes the header with seq unchanged, then the sample.
- enable drops between header and sample → header written, sample not written, FSM IDLE. Re-enable → header seq=1. arstn pulse mid-EMIT → all outputs 0 immediately.
